strip_frame_assembler: RTL and testbench
========================================

# strip_frame_assembler

Parametrised strip-link frame assembler with lock tracking. It sits behind the strip deserialiser in the clk160 domain and packs bursts of header-tagged words into full-width frames. It qualifies each burst by length and runs a HUNT/SYNC/LOCKED alignment FSM. It reports link status, a frame counter and a saturating, clearable error counter, replacing the fixed 4×26-bit phase-counter checker.

## Interface
Parameters:
- PAYLOAD_W, 26, payload bits per word
- HDR_W, 4, header bits per word
- HDR_PATTERN, 4'b1010, header value marking a frame word
- WORDS, 4, words per frame (≥2)
- LOCK_FRAMES, 4, consecutive good frames needed to enter LOCKED (≥1)
- MISS_FRAMES, 2, consecutive bad frames that drop LOCKED back to SYNC (≥1)
- ERR_W, 16, error counter width
- CNT_W, 16, frame counter width

Ports:
- clk160  in  1  single clock; all logic is on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- strip_data_in  in  HDR_W+PAYLOAD_W  word {header, payload}, sampled every cycle
- clear_err  in  1  synchronous pulse; zeroes err_cnt
- frame_data  out  WORDS*PAYLOAD_W  assembled frame; first word in MSBs
- frame_valid  out  1  one-cycle strobe; frame_data is valid on it
- frame_err  out  1  one-cycle strobe for a burst of wrong length
- linked  out  1  high while in LOCKED
- state  out  2  00 HUNT, 01 SYNC, 10 LOCKED
- frame_cnt  out  CNT_W  count of good frames; wraps
- err_cnt  out  ERR_W  count of bad frames; saturates at all-ones

## Operation
- A word is a header word when strip_data_in[HDR_W+PAYLOAD_W-1 -: HDR_W] == HDR_PATTERN. A burst is a maximal run of consecutive header words. A burst ends on the first non-header word.
- Burst length counter: reset to 0 on each non-header word; increments per header word; saturates at WORDS+1. Payloads are shifted into a WORDS×PAYLOAD_W register only while length < WORDS, so extra words never corrupt the held frame.
- At burst end, a burst is good when length == WORDS; otherwise it is bad (short or long).
- HUNT, entered on reset: all bursts are ignored. Move to SYNC on the first non-header word. A burst already in flight at reset release is therefore discarded.
- SYNC:
  - good burst: good_run++; when good_run reaches LOCK_FRAMES, go to LOCKED with good_run cleared.
  - bad burst: good_run = 0.
- LOCKED:
  - good burst: bad_run = 0.
  - bad burst: bad_run++; when bad_run reaches MISS_FRAMES, go to SYNC with both runs cleared.
- In SYNC and LOCKED, a good burst produces: frame_valid pulse, frame_data update, frame_cnt+1.
- In SYNC and LOCKED, a bad burst produces: frame_err pulse, err_cnt+1 (saturating). frame_data holds its last good value.
- HUNT produces neither strobe and changes neither counter.
- clear_err sets err_cnt to 0. If clear_err coincides with a bad-burst increment, clear wins and err_cnt = 0.
- A burst at the maximum rate (one idle word between bursts) is handled with no lost frames.

## Timing
- Reset (asynchronous, reset_n low), all outputs and registers:
  - frame_data = 0, frame_valid = 0, frame_err = 0, linked = 0
  - state = HUNT, frame_cnt = 0, err_cnt = 0
  - length, good_run, bad_run = 0
- Latency: if the terminating non-header word is sampled at edge E, then frame_valid or frame_err, frame_data, the counters, state and linked all update at edge E. The strobes are high for exactly the cycle after E.
- linked rises in the same cycle as the frame_valid of the LOCK_FRAMES-th consecutive good frame. It falls in the same cycle as the frame_err that reaches MISS_FRAMES.
- A burst still running never emits. There is no timeout: a burst of unbounded length counts as one bad frame when it ends.
- Reset asserted mid-burst: the partial frame is lost, and HUNT waits for the next non-header word.
- The frame_cnt wrap from all-ones to 0 is silent.

## Test plan
- Reset release into idle, then 4 bursts of 4 header words with payloads 0x1,0x2,0x3,0x4, separated by one idle word -> 4 frame_valid pulses; frame_data = {26'h1,26'h2,26'h3,26'h4}; state 01 for the first 3 frames; linked = 1 and state = 10 together with the 4th pulse; frame_cnt = 4.
- While LOCKED, a burst of 3 and then a burst of 5 -> two frame_err pulses, err_cnt = 2, state returns to 01 and linked = 0 on the second pulse, and frame_data is unchanged.
- While LOCKED, alternate bad, good, bad bursts -> bad_run resets on the good burst; linked stays 1 and err_cnt = 2.
- Reset released mid-burst (2 header words remain, then idle) -> no strobes; next 4-word burst gives frame_valid in SYNC; frame_cnt = 1.
- ERR_W=2, 5 bad bursts -> err_cnt = 3 (saturated); a clear_err pulse coincident with the next bad burst -> err_cnt = 0 and frame_err still pulses.
- Assert reset_n low mid-burst while LOCKED -> all outputs are zero or HUNT immediately (asynchronously), and the partial burst is never emitted.

Source files
------------

// File: rtl/strip_frame_assembler_if.sv
// Strip-link frame assembler bus: deserialised words in, assembled frames,
// strobes, link status and counters out.
interface strip_frame_assembler_if #(
  parameter int PAYLOAD_W = 26,
  parameter int HDR_W     = 4,
  parameter int WORDS     = 4,
  parameter int ERR_W     = 16,
  parameter int CNT_W     = 16
);
  logic [HDR_W+PAYLOAD_W-1:0] strip_data_in;
  logic                       clear_err;
  logic [WORDS*PAYLOAD_W-1:0] frame_data;
  logic                       frame_valid;
  logic                       frame_err;
  logic                       linked;
  logic [1:0]                 state;
  logic [CNT_W-1:0]           frame_cnt;
  logic [ERR_W-1:0]           err_cnt;

  // Source side: the deserialiser feeding words and the consumer of frames.
  modport master (
    output strip_data_in, clear_err,
    input  frame_data, frame_valid, frame_err, linked, state, frame_cnt, err_cnt
  );

  // Assembler side.
  modport slave (
    input  strip_data_in, clear_err,
    output frame_data, frame_valid, frame_err, linked, state, frame_cnt, err_cnt
  );
endinterface

// File: rtl/strip_frame_assembler.sv
// Packs bursts of header-tagged strip words into full-width frames, qualifies
// each burst by length and tracks link alignment with a HUNT/SYNC/LOCKED FSM.
module strip_frame_assembler #(
  parameter int               PAYLOAD_W   = 26,
  parameter int               HDR_W       = 4,
  parameter logic [HDR_W-1:0] HDR_PATTERN = 4'b1010,
  parameter int               WORDS       = 4,
  parameter int               LOCK_FRAMES = 4,
  parameter int               MISS_FRAMES = 2,
  parameter int               ERR_W       = 16,
  parameter int               CNT_W       = 16
) (
  input  logic                    clk160,
  input  logic                    reset_n,
  strip_frame_assembler_if.slave  bus
);

  localparam int WORD_W  = HDR_W + PAYLOAD_W;
  localparam int FRAME_W = WORDS * PAYLOAD_W;
  localparam int LEN_W   = $clog2(WORDS + 2);
  localparam int GR_W    = $clog2(LOCK_FRAMES + 1);
  localparam int BR_W    = $clog2(MISS_FRAMES + 1);

  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(WORDS);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(WORDS + 1);
  localparam logic [GR_W-1:0]  GR_LAST  = GR_W'(LOCK_FRAMES - 1);
  localparam logic [BR_W-1:0]  BR_LAST  = BR_W'(MISS_FRAMES - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    SYNC   = 2'b01,
    LOCKED = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [GR_W-1:0]    good_q, good_d;
  logic [BR_W-1:0]    bad_q, bad_d;
  logic [LEN_W-1:0]   len_q;
  logic [FRAME_W-1:0] shreg_q;
  logic [FRAME_W-1:0] frame_q;
  logic               valid_q, err_q;
  logic [CNT_W-1:0]   fcnt_q;
  logic [ERR_W-1:0]   ecnt_q;

  logic is_hdr, burst_end, burst_good, emit_good, emit_bad;

  assign is_hdr     = (bus.strip_data_in[WORD_W-1 -: HDR_W] == HDR_PATTERN);
  assign burst_end  = !is_hdr && (len_q != '0);
  assign burst_good = (len_q == LEN_FULL);

  // Burst length tracking (saturating) and payload capture for the first WORDS words.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  // NOTE: the shift register is reset too, so frame_data never exposes stale contents after reset.
  always_ff @(posedge clk160 or negedge reset_n) begin
    if (!reset_n) begin
      len_q   <= '0;
      shreg_q <= '0;
    end else if (is_hdr) begin
      if (len_q != LEN_MAX) len_q <= len_q + LEN_W'(1);
      if (len_q < LEN_FULL)
        shreg_q <= {shreg_q[FRAME_W-PAYLOAD_W-1:0], bus.strip_data_in[PAYLOAD_W-1:0]};
    end else begin
      len_q <= '0;
    end
  end

  // FSM state and run counters.
  always_ff @(posedge clk160 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HUNT;
      good_q  <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
    end
  end

  // Next-state and run-counter update on burst completion.
  // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    case (state_q)
      HUNT: if (!is_hdr) state_d = SYNC;
      SYNC: if (burst_end) begin
        if (!burst_good)          good_d = '0;
        else if (good_q == GR_LAST) begin
          state_d = LOCKED;
          good_d  = '0;
          bad_d   = '0;
        end else                  good_d = good_q + GR_W'(1);
      end
      LOCKED: if (burst_end) begin
        if (burst_good)           bad_d = '0;
        else if (bad_q == BR_LAST) begin
          state_d = SYNC;
          good_d  = '0;
          bad_d   = '0;
        end else                  bad_d = bad_q + BR_W'(1);
      end
      default: state_d = HUNT;
    endcase
  end

  // Output decisions: HUNT swallows every burst.
  always_comb begin
    emit_good = burst_end && burst_good  && (state_q != HUNT);
    emit_bad  = burst_end && !burst_good && (state_q != HUNT);
  end

  // Registered strobes, held frame and counters; clear_err beats a coincident increment.
  always_ff @(posedge clk160 or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      frame_q <= '0;
      fcnt_q  <= '0;
      ecnt_q  <= '0;
    end else begin
      valid_q <= emit_good;
      err_q   <= emit_bad;
      if (emit_good) begin
        frame_q <= shreg_q;
        fcnt_q  <= fcnt_q + CNT_W'(1);
      end
      if (bus.clear_err)                   ecnt_q <= '0;
      else if (emit_bad && ecnt_q != '1)   ecnt_q <= ecnt_q + ERR_W'(1);
    end
  end

  assign bus.frame_data  = frame_q;
  assign bus.frame_valid = valid_q;
  assign bus.frame_err   = err_q;
  assign bus.linked      = (state_q == LOCKED);
  assign bus.state       = state_q;
  assign bus.frame_cnt   = fcnt_q;
  assign bus.err_cnt     = ecnt_q;

endmodule

// File: tb/tb_strip_frame_assembler.sv
// Directed bench for strip_frame_assembler: lock-in, bad bursts, run reset,
// mid-burst reset, and error-counter saturation/clear on a narrow instance.
module tb_strip_frame_assembler;

  logic         clk160 = 1'b0;
  logic         reset_n = 1'b0;
  logic         reset2_n = 1'b0;
  logic [29:0]  data = '0;
  logic         clear = 1'b0;
  int           checks = 0;
  int           errors = 0;
  logic [103:0] exp_frame;

  always #5 clk160 = ~clk160;

  strip_frame_assembler_if bus ();
  strip_frame_assembler_if #(.ERR_W(2)) bus2 ();

  assign bus.strip_data_in  = data;
  assign bus.clear_err      = clear;
  assign bus2.strip_data_in = data;
  assign bus2.clear_err     = clear;

  strip_frame_assembler dut (.clk160(clk160), .reset_n(reset_n), .bus(bus));
  strip_frame_assembler #(.ERR_W(2)) dut2 (.clk160(clk160), .reset_n(reset2_n), .bus(bus2));

  // One word per cycle; returns just after the edge that sampled it.
  task automatic word(input logic hdr, input logic [25:0] pl);
    @(negedge clk160);
    data = {(hdr ? 4'b1010 : 4'b0000), pl};
    @(posedge clk160);
    #1;
  endtask

  // n header words with payloads base, base+1, ... then one idle word.
  task automatic burst(input int n, input int base);
    for (int i = 0; i < n; i++) word(1'b1, 26'(base + i));
    word(1'b0, 26'h0);
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk160);
    #1;
    checks++; if (bus.state !== 2'b00) begin errors++; $display("FAIL rst_state: got %b expected 00", bus.state); end
    checks++; if ({bus.frame_valid, bus.frame_err, bus.linked} !== 3'b000) begin errors++; $display("FAIL rst_strobes: got %b expected 000", {bus.frame_valid, bus.frame_err, bus.linked}); end
    checks++; if (bus.frame_data !== 104'h0) begin errors++; $display("FAIL rst_data: got %h expected 0", bus.frame_data); end
    checks++; if ({bus.frame_cnt, bus.err_cnt} !== 32'h0) begin errors++; $display("FAIL rst_cnt: got %h expected 0", {bus.frame_cnt, bus.err_cnt}); end
    @(negedge clk160);
    reset_n = 1'b1;
    word(1'b0, 26'h0);
    checks++; if (bus.state !== 2'b01) begin errors++; $display("FAIL hunt_to_sync: got %b expected 01", bus.state); end
  endtask

  task automatic test_lock;
    exp_frame = {26'h1, 26'h2, 26'h3, 26'h4};
    for (int b = 1; b <= 4; b++) begin
      burst(4, 1);
      checks++; if (bus.frame_valid !== 1'b1) begin errors++; $display("FAIL lock_valid%0d: got %b expected 1", b, bus.frame_valid); end
      checks++; if (bus.state !== (b == 4 ? 2'b10 : 2'b01)) begin errors++; $display("FAIL lock_state%0d: got %b expected %b", b, bus.state, (b == 4 ? 2'b10 : 2'b01)); end
      checks++; if (bus.linked !== (b == 4)) begin errors++; $display("FAIL lock_linked%0d: got %b expected %b", b, bus.linked, (b == 4)); end
      checks++; if (bus.frame_data !== exp_frame) begin errors++; $display("FAIL lock_data%0d: got %h expected %h", b, bus.frame_data, exp_frame); end
    end
    checks++; if (bus.frame_cnt !== 16'd4) begin errors++; $display("FAIL lock_cnt: got %0d expected 4", bus.frame_cnt); end
    word(1'b0, 26'h0);
    checks++; if (bus.frame_valid !== 1'b0) begin errors++; $display("FAIL strobe_width: got %b expected 0", bus.frame_valid); end
  endtask

  task automatic test_bad_bursts;
    burst(3, 5);
    checks++; if ({bus.frame_err, bus.frame_valid, bus.linked, bus.state} !== 5'b10110) begin errors++; $display("FAIL short_burst: got %b expected 10110", {bus.frame_err, bus.frame_valid, bus.linked, bus.state}); end
    checks++; if (bus.err_cnt !== 16'd1) begin errors++; $display("FAIL short_errcnt: got %0d expected 1", bus.err_cnt); end
    burst(5, 8);
    checks++; if ({bus.frame_err, bus.frame_valid, bus.linked, bus.state} !== 5'b10001) begin errors++; $display("FAIL long_burst: got %b expected 10001", {bus.frame_err, bus.frame_valid, bus.linked, bus.state}); end
    checks++; if (bus.err_cnt !== 16'd2) begin errors++; $display("FAIL long_errcnt: got %0d expected 2", bus.err_cnt); end
    checks++; if (bus.frame_data !== exp_frame) begin errors++; $display("FAIL bad_hold_data: got %h expected %h", bus.frame_data, exp_frame); end
    checks++; if (bus.frame_cnt !== 16'd4) begin errors++; $display("FAIL bad_hold_cnt: got %0d expected 4", bus.frame_cnt); end
  endtask

  task automatic test_run_reset;
    clear = 1'b1;
    word(1'b0, 26'h0);
    clear = 1'b0;
    checks++; if (bus.err_cnt !== 16'd0) begin errors++; $display("FAIL clear_err: got %0d expected 0", bus.err_cnt); end
    for (int b = 0; b < 4; b++) burst(4, 16);
    checks++; if (bus.linked !== 1'b1) begin errors++; $display("FAIL relock: got %b expected 1", bus.linked); end
    burst(2, 0);
    checks++; if ({bus.frame_err, bus.linked} !== 2'b11) begin errors++; $display("FAIL alt_bad1: got %b expected 11", {bus.frame_err, bus.linked}); end
    burst(4, 32);
    exp_frame = {26'h20, 26'h21, 26'h22, 26'h23};
    checks++; if (bus.frame_valid !== 1'b1 || bus.frame_data !== exp_frame) begin errors++; $display("FAIL alt_good: got %b/%h expected 1/%h", bus.frame_valid, bus.frame_data, exp_frame); end
    burst(3, 0);
    checks++; if ({bus.frame_err, bus.linked, bus.state} !== 4'b1110) begin errors++; $display("FAIL alt_bad2: got %b expected 1110", {bus.frame_err, bus.linked, bus.state}); end
    checks++; if (bus.err_cnt !== 16'd2) begin errors++; $display("FAIL alt_errcnt: got %0d expected 2", bus.err_cnt); end
    checks++; if (bus.frame_cnt !== 16'd9) begin errors++; $display("FAIL alt_fcnt: got %0d expected 9", bus.frame_cnt); end
  endtask

  task automatic test_reset_mid_burst;
    word(1'b1, 26'h3F);
    word(1'b1, 26'h3E);
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({bus.state, bus.linked, bus.frame_valid, bus.frame_err} !== 5'b00000) begin errors++; $display("FAIL async_rst_status: got %b expected 00000", {bus.state, bus.linked, bus.frame_valid, bus.frame_err}); end
    checks++; if ({bus.frame_data, bus.frame_cnt, bus.err_cnt} !== 136'h0) begin errors++; $display("FAIL async_rst_regs: got %h expected 0", {bus.frame_data, bus.frame_cnt, bus.err_cnt}); end
    @(negedge clk160);
    data = {4'b1010, 26'h3D};
    reset_n = 1'b1;
    @(posedge clk160);
    #1;
    word(1'b1, 26'h3C);
    word(1'b0, 26'h0);
    checks++; if ({bus.frame_valid, bus.frame_err, bus.state} !== 4'b0001) begin errors++; $display("FAIL midburst_discard: got %b expected 0001", {bus.frame_valid, bus.frame_err, bus.state}); end
    burst(4, 64);
    checks++; if ({bus.frame_valid, bus.state} !== 3'b101) begin errors++; $display("FAIL post_rst_frame: got %b expected 101", {bus.frame_valid, bus.state}); end
    checks++; if (bus.frame_cnt !== 16'd1) begin errors++; $display("FAIL post_rst_cnt: got %0d expected 1", bus.frame_cnt); end
  endtask

  task automatic test_err_saturate;
    checks++; if (bus2.err_cnt !== 2'd0 || bus2.state !== 2'b00) begin errors++; $display("FAIL sat_in_reset: got %0d/%b expected 0/00", bus2.err_cnt, bus2.state); end
    @(negedge clk160);
    data = '0;
    reset2_n = 1'b1;
    word(1'b0, 26'h0);
    for (int b = 1; b <= 5; b++) begin
      burst(2, 0);
      checks++; if (bus2.frame_err !== 1'b1) begin errors++; $display("FAIL sat_err%0d: got %b expected 1", b, bus2.frame_err); end
      checks++; if (bus2.err_cnt !== 2'((b > 3) ? 3 : b)) begin errors++; $display("FAIL sat_cnt%0d: got %0d expected %0d", b, bus2.err_cnt, (b > 3) ? 3 : b); end
    end
    word(1'b1, 26'h0);
    word(1'b1, 26'h0);
    clear = 1'b1;
    word(1'b0, 26'h0);
    clear = 1'b0;
    checks++; if ({bus2.frame_err, bus2.err_cnt} !== 3'b100) begin errors++; $display("FAIL clear_wins: got %b expected 100", {bus2.frame_err, bus2.err_cnt}); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_lock;
    test_bad_bursts;
    test_run_reset;
    test_reset_mid_burst;
    test_err_saturate;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
